wb_rr_arbiter: RTL and testbench

- Round-robin Wishbone B4 classic arbiter that lets up to NUM_M bus masters share one slave port.
- Typical masters: core, caravel bridge, testio, debug.
- Sits in front of the soc_top peripheral interconnect, so that more than one master can reach the same slave decoder.
- Bus ownership is granted per cycle (cyc) and held until the owning master drops cyc.

---
 rtl/wb_rr_arbiter_pkg.sv | 18 +
 rtl/wb_rr_arbiter_rr_pick.sv | 35 +++
 rtl/wb_rr_arbiter.sv | 129 ++++++++++++
 tb/tb_wb_rr_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_rr_arbiter_pkg.sv
// Shared configuration for the Wishbone round-robin arbiter: bus widths, FSM
// state encoding, default ack-watchdog limit and the pointer wrap helper.
package wb_rr_arbiter_pkg;

  localparam int WB_AD_WIDTH    = 32;
  localparam int WB_DAT_WIDTH   = 32;
  localparam int WB_ARB_TIMEOUT = 255;

  typedef enum logic {
    WB_ARB_IDLE = 1'b0,
    WB_ARB_BUSY = 1'b1
  } arb_state_e;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or above ptr, with
// wrap-around, wins. Returns both a one-hot grant and its index.
module rr_pick
  import wb_rr_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  int unsigned j;
  logic        found;

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves it
    // unassigned (no latch); '=' because this is ordered combinational evaluation.
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 32'(ptr);
    for (int k = 0; k < N; k++) begin
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
      j = rr_next(j, N);
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 classic arbiter: NUM_M masters share one slave port,
// ownership held for a whole cyc. Optional ack watchdog under WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int NUM_M   = 4,
  parameter int AW      = WB_AD_WIDTH,
  parameter int DW      = WB_DAT_WIDTH,
  parameter int TIMEOUT = WB_ARB_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_M-1:0]        m_cyc_i,
  input  logic [NUM_M-1:0]        m_stb_i,
  input  logic [NUM_M-1:0]        m_we_i,
  input  logic [NUM_M*AW-1:0]     m_addr_i,
  input  logic [NUM_M*DW-1:0]     m_wdata_i,
  input  logic [NUM_M*DW/8-1:0]   m_sel_i,
  output logic [DW-1:0]           m_rdata_o,
  output logic [NUM_M-1:0]        m_ack_o,
  output logic [NUM_M-1:0]        m_err_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [AW-1:0]           s_addr_o,
  output logic [DW-1:0]           s_wdata_o,
  output logic [DW/8-1:0]         s_sel_o,
  input  logic [DW-1:0]           s_rdata_i,
  input  logic                    s_ack_i,
  output logic [NUM_M-1:0]        grant_o
);

  localparam int SW = DW / 8;
  localparam int PW = $clog2(NUM_M);

  if (NUM_M < 2 || NUM_M > 4 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_cfg
    $error("wb_rr_arbiter: NUM_M must be 2..4 and TIMEOUT 1..65535");
  end

  arb_state_e       state;
  logic [PW-1:0]    owner;
  logic [PW-1:0]    ptr;
  logic [NUM_M-1:0] pick;
  logic [PW-1:0]    pick_idx;
  logic             busy, own_cyc, own_stb;
  logic             expire, cut;

  rr_pick #(.N(NUM_M), .PW(PW)) u_pick (
    .req (m_cyc_i),
    .ptr (ptr),
    .gnt (pick),
    .idx (pick_idx)
  );

  assign busy    = (state == WB_ARB_BUSY);
  assign own_cyc = busy & m_cyc_i[owner];
  assign own_stb = own_cyc & m_stb_i[owner];

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        timed_out;

  // Once the limit is hit the slave stays cut off until the master gives up cyc.
  assign expire = own_stb & ~s_ack_i & ~timed_out & (wd_cnt == 16'(TIMEOUT - 1));
  assign cut    = timed_out | expire;

  always_ff @(posedge clk) begin
    if (!rst || !own_cyc) begin
      wd_cnt    <= '0;
      timed_out <= 1'b0;
    end else begin
      if (expire) timed_out <= 1'b1;
      if (!own_stb || s_ack_i || cut) wd_cnt <= '0;
      else                            wd_cnt <= wd_cnt + 16'd1;
    end
  end
`else
  assign expire = 1'b0;
  assign cut    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    // NOTE: '<=' so every register here updates from pre-edge values together.
    if (!rst) begin
      state   <= WB_ARB_IDLE;
      grant_o <= '0;
      owner   <= '0;
      ptr     <= '0;
    end else begin
      case (state)
        WB_ARB_IDLE: if (|m_cyc_i) begin
          grant_o <= pick;
          owner   <= pick_idx;
          state   <= WB_ARB_BUSY;
        end
        WB_ARB_BUSY: if (!m_cyc_i[owner]) begin
          grant_o <= '0;
          ptr     <= PW'(rr_next(32'(owner), NUM_M));
          state   <= WB_ARB_IDLE;
        end
        default: state <= WB_ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    s_sel_o   = '0;
    m_ack_o   = '0;
    m_err_o   = '0;
    if (busy) begin
      s_cyc_o        = own_cyc & ~cut;
      s_stb_o        = own_stb & ~cut;
      s_we_o         = m_we_i[owner];
      s_addr_o       = m_addr_i[int'(owner)*AW +: AW];
      s_wdata_o      = m_wdata_i[int'(owner)*DW +: DW];
      s_sel_o        = m_sel_i[int'(owner)*SW +: SW];
      m_ack_o[owner] = own_cyc & ~cut & s_ack_i;
      m_err_o[owner] = expire;
    end
  end

  assign m_rdata_o = s_rdata_i;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: arbitration vector table, directed
// transfer sequences, and randomized traffic against a priority-queue model.
module tb_wb_rr_arbiter;

  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic               clk;
  logic               rst;
  logic [NM-1:0]      m_cyc_i, m_stb_i, m_we_i;
  logic [NM*AW-1:0]   m_addr_i;
  logic [NM*DW-1:0]   m_wdata_i;
  logic [NM*SW-1:0]   m_sel_i;
  logic [DW-1:0]      m_rdata_o;
  logic [NM-1:0]      m_ack_o, m_err_o;
  logic               s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]      s_addr_o;
  logic [DW-1:0]      s_wdata_o, s_rdata_i;
  logic [SW-1:0]      s_sel_o;
  logic               s_ack_i;
  logic [NM-1:0]      grant_o;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [NM-1:0] req;
    logic [NM-1:0] exp;
  } arb_vec_t;

  arb_vec_t vecs[11];

  wb_rr_arbiter #(.NUM_M(NM), .AW(AW), .DW(DW), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i), .m_sel_i(m_sel_i),
    .m_rdata_o(m_rdata_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_sel_o(s_sel_o),
    .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i), .grant_o(grant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int onehot_idx(input logic [NM-1:0] v);
    int r = -1;
    for (int i = 0; i < NM; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_addr_i = '0; m_wdata_i = '0; m_sel_i = '0;
    s_ack_i = 1'b0; s_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Read traffic with a responsive slave: acks every strobe, rdata = 0xA0 + master.
  task automatic run_reads(input logic [NM-1:0] req, input int n_xfer, input bit again,
                           input int exp_order[6], input int n_exp, input string tag);
    int            order[$];
    int            idle_run, acks;
    logic [NM-1:0] prev, hold, cool;
    m_cyc_i = req; m_stb_i = req; m_we_i = '0;
    for (int i = 0; i < NM; i++) m_addr_i[i*AW +: AW] = 32'(i * 4);
    hold = '0; cool = '0; prev = '0; idle_run = 0; acks = 0;
    for (int c = 0; c < 80 && acks < n_xfer; c++) begin
      #1;
      s_ack_i   = s_cyc_o & s_stb_o;
      s_rdata_i = 32'hA0 + 32'(s_addr_o[3:2]);
      @(negedge clk);
      if (grant_o != '0 && grant_o != prev) begin
        order.push_back(onehot_idx(grant_o));
        if (order.size() > 1) check({tag, "_idle_gap"}, idle_run, 1);
        idle_run = 0;
      end else if (grant_o == '0 && order.size() > 0) begin
        idle_run++;
      end
      for (int i = 0; i < NM; i++) if (m_ack_o[i]) begin
        check($sformatf("%s_rdata_m%0d", tag, i), m_rdata_o, 32'hA0 + i);
        acks++;
        hold[i] = 1'b1;
      end
      prev = grant_o;
      tick();
      s_ack_i = 1'b0;
      for (int i = 0; i < NM; i++) begin
        if (cool[i]) begin
          cool[i] = 1'b0;
          if (again) begin m_cyc_i[i] = 1'b1; m_stb_i[i] = 1'b1; end
        end
        if (hold[i]) begin
          hold[i] = 1'b0; cool[i] = 1'b1;
          m_cyc_i[i] = 1'b0; m_stb_i[i] = 1'b0;
        end
      end
    end
    m_cyc_i = '0; m_stb_i = '0;
    tick(); tick();
    check({tag, "_xfers"}, acks, n_xfer);
    check({tag, "_order_len"}, order.size(), n_exp);
    for (int k = 0; k < n_exp; k++)
      if (k < order.size()) check($sformatf("%s_order%0d", tag, k), order[k], exp_order[k]);
  endtask

  // Randomized masters/slave; model keeps a rotating priority queue where the
  // released master moves to the back of the rotation.
  task automatic run_random(input int n_cycles);
    int            prio[$];
    int            owner;
    int            hold[NM];
    logic [70:0]   exp_bus;
    logic [NM-1:0] exp_ack, exp_grant;
    prio = {0, 1, 2, 3};
    owner = -1;
    for (int i = 0; i < NM; i++) hold[i] = 0;
    for (int c = 0; c < n_cycles; c++) begin
      @(negedge clk);
      exp_bus = '0; exp_ack = '0; exp_grant = '0;
      if (owner >= 0) begin
        exp_grant[owner] = 1'b1;
        exp_bus = {m_cyc_i[owner], m_cyc_i[owner] & m_stb_i[owner], m_we_i[owner],
                   m_addr_i[owner*AW +: AW], m_wdata_i[owner*DW +: DW], m_sel_i[owner*SW +: SW]};
        exp_ack[owner] = m_cyc_i[owner] & s_ack_i;
      end
      check("rnd_grant", grant_o, exp_grant);
      check("rnd_sbus", {s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_wdata_o, s_sel_o}, exp_bus);
      check("rnd_ack", m_ack_o, exp_ack);
      check("rnd_err", m_err_o, '0);
      check("rnd_rdata", m_rdata_o, s_rdata_i);
      @(posedge clk);
      if (!rst) begin
        prio = {0, 1, 2, 3};
        owner = -1;
      end else if (owner < 0) begin
        for (int k = 0; k < NM; k++) if (owner < 0 && m_cyc_i[prio[k]]) owner = prio[k];
      end else if (!m_cyc_i[owner]) begin
        while (prio[$] != owner) prio.push_back(prio.pop_front());
        owner = -1;
      end
      #1;
      rst = ($urandom_range(0, 79) != 0);
      for (int i = 0; i < NM; i++) begin
        if (hold[i] > 0) begin
          hold[i]--;
          if (hold[i] == 0) m_cyc_i[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          m_cyc_i[i] = 1'b1;
          hold[i] = $urandom_range(1, 6);
        end
        m_stb_i[i] = m_cyc_i[i] & 1'($urandom_range(0, 1));
        m_we_i[i]  = 1'($urandom_range(0, 1));
        m_addr_i[i*AW +: AW]  = $urandom;
        m_wdata_i[i*DW +: DW] = $urandom;
        m_sel_i[i*SW +: SW]   = 4'($urandom);
      end
      s_ack_i   = 1'($urandom_range(0, 1));
      s_rdata_i = $urandom;
    end
    rst = 1'b1;
    m_cyc_i = '0; m_stb_i = '0;
    tick(); tick();
  endtask

  initial begin
    // {request vector, expected grant}, applied in order from reset (pointer 0)
    vecs[0]  = '{4'b0010, 4'b0010};
    vecs[1]  = '{4'b1111, 4'b0100};
    vecs[2]  = '{4'b0011, 4'b0001};
    vecs[3]  = '{4'b0001, 4'b0001};
    vecs[4]  = '{4'b1000, 4'b1000};
    vecs[5]  = '{4'b1010, 4'b0010};
    vecs[6]  = '{4'b0011, 4'b0001};
    vecs[7]  = '{4'b1100, 4'b0100};
    vecs[8]  = '{4'b0111, 4'b0001};
    vecs[9]  = '{4'b0000, 4'b0000};
    vecs[10] = '{4'b0101, 4'b0100};

    do_reset();
    @(negedge clk);
    check("rst_grant", grant_o, '0);
    check("rst_sbus", {s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_wdata_o, s_sel_o}, '0);
    check("rst_ack_err", {m_ack_o, m_err_o}, '0);
    tick();

    foreach (vecs[v]) begin
      m_cyc_i = vecs[v].req;
      tick();
      @(negedge clk);
      check($sformatf("vec%0d_grant", v), grant_o, vecs[v].exp);
      check($sformatf("vec%0d_scyc", v), s_cyc_o, vecs[v].exp != '0);
      tick();
      m_cyc_i = '0;
      tick();
    end

    // Single master write from m1, slave acks two cycles after the grant
    do_reset();
    m_cyc_i = 4'b0010; m_stb_i = 4'b0010; m_we_i = 4'b0010;
    m_addr_i[AW +: AW] = 32'h1000_0004;
    m_wdata_i[DW +: DW] = 32'hDEAD_BEEF;
    m_sel_i[SW +: SW] = 4'hF;
    @(negedge clk);
    check("a_idle_scyc", s_cyc_o, 1'b0);
    tick();
    @(negedge clk);
    check("a_grant", grant_o, 4'b0010);
    check("a_cyc_stb", {s_cyc_o, s_stb_o}, 2'b11);
    check("a_bus", {s_we_o, s_addr_o, s_wdata_o, s_sel_o}, {1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF});
    check("a_ack_wait0", m_ack_o, '0);
    tick();
    @(negedge clk);
    check("a_ack_wait1", m_ack_o, '0);
    tick();
    s_ack_i = 1'b1;
    @(negedge clk);
    check("a_ack", m_ack_o, 4'b0010);
    tick();
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    @(negedge clk);
    check("a_late_ack", m_ack_o, '0);
    check("a_drop_scyc", s_cyc_o, 1'b0);
    tick();
    @(negedge clk);
    check("a_stray_ack", m_ack_o, '0);
    check("a_idle_grant", grant_o, '0);
    tick();
    @(negedge clk);
    check("a_stays_idle", {grant_o, s_cyc_o}, '0);
    tick();
    s_ack_i = 1'b0;

    do_reset();
    run_reads(4'b1111, 4, 1'b0, '{0, 1, 2, 3, 0, 0}, 4, "all4");
    do_reset();
    run_reads(4'b0101, 6, 1'b1, '{0, 2, 0, 2, 0, 2}, 6, "m0m2");

    // Reset while m3 owns the bus with stb high
    do_reset();
    m_cyc_i = 4'b1000; m_stb_i = 4'b1000;
    tick();
    @(negedge clk);
    check("d_grant", grant_o, 4'b1000);
    check("d_stb", s_stb_o, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    s_ack_i = 1'b1;
    @(negedge clk);
    check("d_rst_grant", grant_o, '0);
    check("d_rst_scyc", s_cyc_o, 1'b0);
    check("d_rst_ack", m_ack_o, '0);
    tick();
    s_ack_i = 1'b0;
    @(negedge clk);
    check("d_regrant", grant_o, 4'b1000);
    tick();
    m_cyc_i = '0; m_stb_i = '0;
    tick(); tick();

    // Pointer parked on 2 by an m1 transfer must return to 0 on reset
    m_cyc_i = 4'b0010;
    tick();
    m_cyc_i = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    m_cyc_i = 4'b0101;
    tick();
    @(negedge clk);
    check("d_ptr_reset", grant_o, 4'b0001);
    tick();
    m_cyc_i = '0;
    tick(); tick();

`ifdef WB_ARB_TIMEOUT_EN
    // Dead slave: m2 read never acked, m3 waiting behind it
    do_reset();
    m_cyc_i = 4'b1100; m_stb_i = 4'b0100;
    tick();
    for (int b = 1; b <= 17; b++) begin
      @(negedge clk);
      check($sformatf("to_err_b%0d", b), m_err_o, (b == 16) ? 4'b0100 : 4'b0000);
      check($sformatf("to_scyc_b%0d", b), {s_cyc_o, s_stb_o}, (b < 16) ? 2'b11 : 2'b00);
      tick();
    end
    m_cyc_i = 4'b1000; m_stb_i = '0;
    tick(); tick();
    @(negedge clk);
    check("to_next_grant", grant_o, 4'b1000);
    tick();
    m_cyc_i = '0;
    tick(); tick();
`endif

    do_reset();
    run_random(400);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
